hazard_stall_unit: RTL and testbench
====================================

Name: hazard_stall_unit

Overview:
- Pipeline hazard controller for the 5-stage RISC-V core with a multi-cycle multiplier.
- Consumes the decoded control signals produced for each instruction (mem_read, branch/jump redirect, MUL decode) plus register indices from the ID and EX stages.
- Drives PC, IF/ID and ID/EX write enables, bubble-insertion controls and the IF/ID flush.
- Covers load-use stalls, multi-cycle MUL occupancy of EX, and taken-branch/jump flushes.

Parameters:
- MULT_LATENCY, 3, cycles a MUL occupies EX (legal range 2..15)
- CNT_W, 4, width of the multiplier occupancy counter

Ports:
- clk  in  1  core clock
- arst_n  in  1  reset, asynchronous, active-low
- id_rs1  in  5  rs1 index of instruction in ID
- id_rs2  in  5  rs2 index of instruction in ID
- ex_rd  in  5  rd index of instruction in EX
- ex_mem_read  in  1  EX instruction is a load (control mem_read carried in ID/EX)
- ex_is_mult  in  1  EX instruction is R-type MUL (funct7=0000001)
- ex_redirect  in  1  EX resolved taken branch or jump
- pc_write  out  1  PC update enable
- if_id_write  out  1  IF/ID register enable
- id_ex_write  out  1  ID/EX register enable
- id_ex_bubble  out  1  zero all control fields entering ID/EX
- ex_mem_bubble  out  1  zero all control fields entering EX/MEM
- if_id_flush  out  1  clear IF/ID to NOP
- mult_done  out  1  final EX cycle of a MUL; result valid

Behaviour:
- Idle output values (also forced while arst_n low): pc_write=1, if_id_write=1, id_ex_write=1, all bubbles and flush 0, mult_done=0.
- State (state, cnt) is reset asynchronously to IDLE with cnt=0.
- FSM has two states: IDLE and BUSY. Outputs are combinational from state, cnt and inputs.
- mult_stall = (IDLE & ex_is_mult) | (BUSY & cnt!=0).
- IDLE with ex_is_mult=1: next state BUSY, cnt loaded with MULT_LATENCY-2.
- BUSY with cnt!=0: cnt decrements. BUSY with cnt==0: mult_done=1, no stall, next state IDLE. ex_is_mult is ignored on this transition.
- Resulting timing: a MUL occupies EX for MULT_LATENCY cycles with MULT_LATENCY-1 stall cycles. A back-to-back MUL starts a fresh count the cycle after mult_done.
- mult_stall action: pc_write=0, if_id_write=0, id_ex_write=0, ex_mem_bubble=1.
- load_use = ex_mem_read & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
- load_use action: pc_write=0, if_id_write=0, id_ex_bubble=1. This is a single cycle; the next cycle the load has left EX.
- ex_redirect action: if_id_flush=1, id_ex_bubble=1; PC keeps pc_write=1 to take the target.
- Priority: mult_stall > ex_redirect > load_use. ex_redirect during mult_stall cannot occur legally; if it does, it is ignored.
- Load-use and redirect in the same cycle: the redirect wins, because the ID instruction is squashed anyway.
- rd=x0 never causes a stall.
- Reset mid-MUL: immediate return to IDLE; the outstanding MUL is abandoned.
- cnt never wraps. MULT_LATENCY<2 is a compile-time error.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- When defined, two extra outputs are present:
  - stall_cycles, 32 bits: counts cycles with pc_write=0.
  - flush_count, 32 bits: counts cycles with if_id_flush=1.
- Both counters saturate at 0xFFFFFFFF and are cleared by arst_n.
- When not defined, neither the ports nor the counter logic exist.

Decomposition:
- Package hazard_pkg holds:
  - state encoding (IDLE=1'b0, BUSY=1'b1)
  - REG_X0=5'd0
  - the MUL funct7 constant 7'b0000001
  - CNT_W default
- Sub-module mult_occupancy_ctr holds the IDLE/BUSY FSM and cnt. It outputs mult_stall and mult_done.
- The top level holds the load-use compare, the priority mux and the optional stats counters.

Test Plan:
- Reset: arst_n low mid-BUSY (cnt=1) -> next edge state IDLE; outputs at idle values while low; mult_done never pulses.
- Load-use: ex_mem_read=1, ex_rd=5, id_rs2=5 -> one cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; normal the next cycle. Same stimulus with ex_rd=0 -> no stall.
- MUL with MULT_LATENCY=3: ex_is_mult held 3 cycles -> stall in cycles 0-1, mult_done=1 in cycle 2, idle in cycle 3. Back-to-back MUL -> second stall begins in cycle 3.
- Redirect: ex_redirect=1 -> if_id_flush=1, id_ex_bubble=1, pc_write=1. Redirect plus load_use in the same cycle -> flush only, pc_write=1.
- Priority: ex_redirect=1 during BUSY cnt=1 -> flush=0, stall outputs held.
- HAZARD_STATS_EN: one MUL (2 stalls) + one load-use + one redirect -> stall_cycles=3, flush_count=1.

Source files
------------

// File: rtl/hazard_stall_unit_pkg.sv
// hazard_pkg: shared state encoding and constants for the hazard stall unit
package hazard_pkg;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;
    localparam logic [4:0] REG_X0 = 5'd0;
    localparam logic [6:0] MUL_FUNCT7 = 7'b0000001;
    localparam int CNT_W_DEF = 4;
endpackage

// File: rtl/hazard_stall_unit_if.sv
// hazard_stall_unit_if: pipeline-to-hazard-unit signals; stats ports exist only with HAZARD_STATS_EN
interface hazard_stall_unit_if;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic [4:0] ex_rd;
    logic ex_mem_read;
    logic ex_is_mult;
    logic ex_redirect;
    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic id_ex_bubble;
    logic ex_mem_bubble;
    logic if_id_flush;
    logic mult_done;
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_redirect,
        input pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done,
        input stall_cycles, flush_count
    );
    modport slave (
        input id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_redirect,
        output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done,
        output stall_cycles, flush_count
    );
`else
    modport master (
        output id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_redirect,
        input pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done
    );
    modport slave (
        input id_rs1, id_rs2, ex_rd, ex_mem_read, ex_is_mult, ex_redirect,
        output pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done
    );
`endif
endinterface

// File: rtl/hazard_stall_unit_mult_occupancy_ctr.sv
// mult_occupancy_ctr: IDLE/BUSY tracker holding EX while a multi-cycle MUL completes
module mult_occupancy_ctr
    import hazard_pkg::*;
#(
    parameter int MULT_LATENCY = 3,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic clk,
    input  logic arst_n,
    input  logic ex_is_mult,
    output logic mult_stall,
    output logic mult_done
);
    if (MULT_LATENCY < 2 || MULT_LATENCY - 2 >= (1 << CNT_W)) begin : g_bad_latency
        $error("MULT_LATENCY must be >= 2 and MULT_LATENCY-2 must fit in CNT_W bits");
    end
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 2);
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        mult_stall = 1'b0;
        mult_done = 1'b0;
        if (state_q == IDLE) begin
            if (ex_is_mult) begin
                state_d = BUSY;
                cnt_d = CNT_LOAD;
                mult_stall = 1'b1;
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
            mult_stall = 1'b1;
        end else begin
            mult_done = 1'b1;
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/hazard_stall_unit.sv
// hazard_stall_unit: load-use/MUL/redirect hazard control; HAZARD_STATS_EN adds stall and flush counters
module hazard_stall_unit
    import hazard_pkg::*;
#(
    parameter int MULT_LATENCY = 3,
    parameter int CNT_W = CNT_W_DEF
) (
    input logic clk,
    input logic arst_n,
    hazard_stall_unit_if.slave hz
);
    logic mult_stall, mult_done_raw, load_use;
    mult_occupancy_ctr #(.MULT_LATENCY(MULT_LATENCY), .CNT_W(CNT_W)) u_mul (
        .clk(clk),
        .arst_n(arst_n),
        .ex_is_mult(hz.ex_is_mult),
        .mult_stall(mult_stall),
        .mult_done(mult_done_raw)
    );
    assign load_use = hz.ex_mem_read && hz.ex_rd != REG_X0 &&
                      (hz.ex_rd == hz.id_rs1 || hz.ex_rd == hz.id_rs2);
    // Outputs sit at idle values while reset is held, regardless of inputs
    always_comb begin
        hz.pc_write = 1'b1;
        hz.if_id_write = 1'b1;
        hz.id_ex_write = 1'b1;
        hz.id_ex_bubble = 1'b0;
        hz.ex_mem_bubble = 1'b0;
        hz.if_id_flush = 1'b0;
        hz.mult_done = 1'b0;
        if (arst_n) begin
            hz.mult_done = mult_done_raw;
            if (mult_stall) begin
                hz.pc_write = 1'b0;
                hz.if_id_write = 1'b0;
                hz.id_ex_write = 1'b0;
                hz.ex_mem_bubble = 1'b1;
            end else if (hz.ex_redirect) begin
                hz.if_id_flush = 1'b1;
                hz.id_ex_bubble = 1'b1;
            end else if (load_use) begin
                hz.pc_write = 1'b0;
                hz.if_id_write = 1'b0;
                hz.id_ex_bubble = 1'b1;
            end
        end
    end
`ifdef HAZARD_STATS_EN
    logic [31:0] stall_cycles_q, stall_cycles_d, flush_count_q, flush_count_d;
    always_comb begin
        stall_cycles_d = (!hz.pc_write && stall_cycles_q != '1) ? stall_cycles_q + 32'd1 : stall_cycles_q;
        flush_count_d = (hz.if_id_flush && flush_count_q != '1) ? flush_count_q + 32'd1 : flush_count_q;
    end
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cycles_q <= '0;
            flush_count_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q <= flush_count_d;
        end
    end
    assign hz.stall_cycles = stall_cycles_q;
    assign hz.flush_count = flush_count_q;
`endif
endmodule

// File: tb/tb_hazard_stall_unit.sv
// tb_hazard_stall_unit: scoreboard bench with a cycle-position reference model of the hazard rules
module tb_hazard_stall_unit;
    localparam int L = 3;
    typedef struct {
        logic [6:0] o;
        int ph;
        int cyc;
    } exp_t;
    logic clk = 1'b0;
    logic arst_n = 1'b0;
    hazard_stall_unit_if hz ();
    hazard_stall_unit #(.MULT_LATENCY(L), .CNT_W(4)) dut (
        .clk(clk),
        .arst_n(arst_n),
        .hz(hz)
    );
    always #5 clk = ~clk;
    exp_t q[$];
    int n_vec = 0;
    int n_err = 0;
    int ph = 0;
    int cyc = 0;
    int mul_age = -1;
    int sc = 0;
    int fc = 0;
    // bit order: pc_write, if_id_write, id_ex_write, id_ex_bubble, ex_mem_bubble, if_id_flush, mult_done
    localparam logic [6:0] IDLE_O = 7'b1110000;
    task automatic step(input logic r, input logic mr, input logic mu, input logic rdr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        int p;
        logic st, dn, lu;
        @(posedge clk);
        #1;
        arst_n = r;
        hz.ex_mem_read = mr;
        hz.ex_is_mult = mu;
        hz.ex_redirect = rdr;
        hz.ex_rd = rd;
        hz.id_rs1 = rs1;
        hz.id_rs2 = rs2;
        e.ph = ph;
        e.cyc = cyc;
        cyc++;
        if (!r) begin
            e.o = IDLE_O;
            mul_age = -1;
            sc = 0;
            fc = 0;
        end else begin
            p = (mul_age < 0) ? (mu ? 0 : -1) : mul_age;
            st = p >= 0 && p < L - 1;
            dn = p == L - 1;
            lu = mr && rd != 0 && (rd == rs1 || rd == rs2);
            if (st) e.o = 7'b0000100;
            else if (rdr) e.o = {6'b111101, dn};
            else if (lu) e.o = {6'b001100, dn};
            else e.o = {6'b111000, dn};
            mul_age = (p < 0 || p == L - 1) ? -1 : p + 1;
            sc += e.o[6] ? 0 : 1;
            fc += e.o[1] ? 1 : 0;
        end
        q.push_back(e);
    endtask
    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
    endtask
    always @(negedge clk) begin
        exp_t e;
        logic [6:0] act;
        if (q.size() != 0) begin
            e = q.pop_front();
            act = {hz.pc_write, hz.if_id_write, hz.id_ex_write, hz.id_ex_bubble,
                   hz.ex_mem_bubble, hz.if_id_flush, hz.mult_done};
            n_vec++;
            if (act !== e.o) begin
                n_err++;
                $display("FAIL outs ph%0d cyc%0d: got %b want %b", e.ph, e.cyc, act, e.o);
            end
        end
    end
    initial begin
        hz.ex_mem_read = 0;
        hz.ex_is_mult = 0;
        hz.ex_redirect = 0;
        hz.ex_rd = 0;
        hz.id_rs1 = 0;
        hz.id_rs2 = 0;
        ph = 0;
        step(1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3);
        step(1'b0, 1'b1, 1'b0, 1'b0, 5'd3, 5'd3, 5'd3);
        idle();
        ph = 1;
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd5, 5'd1, 5'd5);
        idle();
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 5'd2);
        ph = 2;
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        idle();
        repeat (6) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        idle();
        ph = 3;
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b1, 5'd7, 5'd7, 5'd0);
        idle();
        ph = 4;
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 5'd4, 5'd4);
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        idle();
        ph = 5;
        step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) idle();
        ph = 6;
        step(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 5'd6, 5'd6, 5'd1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle();
`ifdef HAZARD_STATS_EN
        n_vec++;
        if (hz.stall_cycles !== 32'd3) begin
            n_err++;
            $display("FAIL stall_cycles scenario: got %0d want 3", hz.stall_cycles);
        end
        n_vec++;
        if (hz.flush_count !== 32'd1) begin
            n_err++;
            $display("FAIL flush_count scenario: got %0d want 1", hz.flush_count);
        end
`endif
        ph = 7;
        for (int i = 0; i < 600; i++) begin
            step($urandom_range(99) != 0, $urandom_range(2) == 0, $urandom_range(5) == 0,
                 $urandom_range(7) == 0, 5'($urandom_range(3)), 5'($urandom_range(3)),
                 5'($urandom_range(3)));
        end
        idle();
        repeat (3) @(negedge clk);
        n_vec++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard drain: got %0d left want 0", q.size());
        end
`ifdef HAZARD_STATS_EN
        n_vec++;
        if (hz.stall_cycles !== 32'(sc)) begin
            n_err++;
            $display("FAIL stall_cycles random: got %0d want %0d", hz.stall_cycles, sc);
        end
        n_vec++;
        if (hz.flush_count !== 32'(fc)) begin
            n_err++;
            $display("FAIL flush_count random: got %0d want %0d", hz.flush_count, fc);
        end
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
